// File: rtl/blink_sequencer.sv
// LED pattern sequencer: walks a packed pattern table at one of NSPEED prescaled rates,
// with up/down speed buttons and forward / reverse / ping-pong / hold sequencing modes.
module blink_sequencer #(
    parameter int                    NLED       = 2,
    parameter int                    NSTEP      = 6,
    parameter int                    DIVW       = 27,
    parameter int                    NSPEED     = 4,
    parameter bit                    ACTIVE_LOW = 1'b1,
    parameter logic [NSTEP*NLED-1:0] PATTERN    = 12'h399
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      BTN_UP,
    input  logic                      BTN_DN,
    input  logic                      BTN_MODE,
    output logic [NLED-1:0]           LED,
    output logic [$clog2(NSTEP)-1:0]  STEP,
    output logic [$clog2(NSPEED)-1:0] SPEED,
    output logic [1:0]                MODE,
    output logic                      TICK
);

    localparam int SW = $clog2(NSTEP);
    localparam int IW = SW + 1;
    localparam int PW = $clog2(NSPEED);
    localparam logic [IW-1:0]   LAST      = IW'(NSTEP - 1);
    localparam logic [PW-1:0]   SPEED_MAX = PW'(NSPEED - 1);
    localparam logic [NLED-1:0] LED_OFF   = {NLED{ACTIVE_LOW}};

    typedef enum logic [1:0] {
        MODE_FWD  = 2'd0,
        MODE_REV  = 2'd1,
        MODE_PING = 2'd2,
        MODE_HOLD = 2'd3
    } mode_t;

    logic [DIVW-1:0] cnt_q, cnt_d, tick_mask;
    logic [SW-1:0]   step_q, step_d;
    logic [IW-1:0]   idx;
    logic [PW-1:0]   speed_q, speed_d;
    mode_t           mode_q, mode_d;
    logic            dir_up_q, dir_up_d;
    logic [NLED-1:0] led_q;
    logic [NLED-1:0] pat_tab [NSTEP];

    for (genvar i = 0; i < NSTEP; i++) begin : g_tab
        assign pat_tab[i] = PATTERN[i*NLED +: NLED];
    end

    // Low DIVW-SPEED count bits all ones: faster speeds compare fewer bits.
    assign tick_mask = {DIVW{1'b1}} >> speed_q;
    assign TICK      = &(cnt_q | ~tick_mask);
    assign idx       = {1'b0, step_q};

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        cnt_d    = cnt_q + DIVW'(1);
        step_d   = step_q;
        speed_d  = speed_q;
        mode_d   = mode_q;
        dir_up_d = dir_up_q;

        if (BTN_UP && !BTN_DN && speed_q != SPEED_MAX)
            speed_d = speed_q + PW'(1);
        else if (BTN_DN && !BTN_UP && speed_q != '0)
            speed_d = speed_q - PW'(1);

        if (TICK) begin
            case (mode_q)
                MODE_FWD: step_d = (idx == LAST) ? '0 : SW'(idx + IW'(1));
                MODE_REV: step_d = (idx == '0) ? SW'(LAST) : SW'(idx - IW'(1));
                MODE_PING: begin
                    if (dir_up_q) begin
                        if (idx == LAST) begin
                            step_d   = SW'(LAST - IW'(1));
                            dir_up_d = 1'b0;
                        end else begin
                            step_d = SW'(idx + IW'(1));
                        end
                    end else begin
                        if (idx == '0) begin
                            step_d   = SW'(1);
                            dir_up_d = 1'b1;
                        end else begin
                            step_d = SW'(idx - IW'(1));
                        end
                    end
                end
                default: ;
            endcase
        end

        // Step logic above uses the pre-press mode; the press only affects later ticks.
        if (BTN_MODE) begin
            mode_d = mode_t'(mode_q + 2'd1);
            if (mode_q == MODE_REV)
                dir_up_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q    <= '0;
            step_q   <= '0;
            speed_q  <= '0;
            mode_q   <= MODE_FWD;
            dir_up_q <= 1'b1;
            led_q    <= LED_OFF;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            cnt_q    <= cnt_d;
            step_q   <= step_d;
            speed_q  <= speed_d;
            mode_q   <= mode_d;
            dir_up_q <= dir_up_d;
            led_q    <= pat_tab[step_q] ^ LED_OFF;
        end
    end

    assign LED   = led_q;
    assign STEP  = step_q;
    assign SPEED = speed_q;
    assign MODE  = mode_q;

endmodule

// File: tb/tb_blink_sequencer.sv
// Randomised bench for blink_sequencer (DIVW=4) against a cycle-count based reference model.
module tb_blink_sequencer;

    localparam int NLED   = 2;
    localparam int NSTEP  = 6;
    localparam int DIVW   = 4;
    localparam int NSPEED = 4;
    localparam logic [NSTEP*NLED-1:0] PAT = 12'h399;

    logic            CLK = 1'b0;
    logic            RST = 1'b0;
    logic            BTN_UP = 1'b0, BTN_DN = 1'b0, BTN_MODE = 1'b0;
    logic [NLED-1:0] LED;
    logic [2:0]      STEP;
    logic [1:0]      SPEED;
    logic [1:0]      MODE;
    logic            TICK;

    int total = 0;
    int bad   = 0;

    // reference model state
    int cyc_m, step_m, speed_m, mode_m, led_m;
    bit dir_up_m;

    blink_sequencer #(
        .NLED(NLED), .NSTEP(NSTEP), .DIVW(DIVW), .NSPEED(NSPEED),
        .ACTIVE_LOW(1'b1), .PATTERN(PAT)
    ) dut (
        .CLK(CLK), .RST(RST), .BTN_UP(BTN_UP), .BTN_DN(BTN_DN), .BTN_MODE(BTN_MODE),
        .LED(LED), .STEP(STEP), .SPEED(SPEED), .MODE(MODE), .TICK(TICK)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0d expected=%0d", tag, $time, got, exp);
        end
    endtask

    function automatic bit m_tick();
        int period = 1 << (DIVW - speed_m);
        return (cyc_m % period) == period - 1;
    endfunction

    function automatic int m_led(input int s);
        logic [NSTEP*NLED-1:0] p = PAT;
        return int'((p >> (s * NLED)) & 2'b11) ^ 3;
    endfunction

    task automatic model_reset();
        cyc_m = 0; step_m = 0; speed_m = 0; mode_m = 0; dir_up_m = 1'b1; led_m = 3;
    endtask

    task automatic model_clock(input bit up, input bit dn, input bit m);
        bit t = m_tick();
        led_m = m_led(step_m);
        if (t) begin
            case (mode_m)
                0: step_m = (step_m + 1) % NSTEP;
                1: step_m = (step_m + NSTEP - 1) % NSTEP;
                2: if (dir_up_m) begin
                       if (step_m == NSTEP - 1) begin step_m = NSTEP - 2; dir_up_m = 1'b0; end
                       else step_m++;
                   end else begin
                       if (step_m == 0) begin step_m = 1; dir_up_m = 1'b1; end
                       else step_m--;
                   end
                default: ;
            endcase
        end
        if (up && !dn) speed_m = (speed_m < NSPEED - 1) ? speed_m + 1 : speed_m;
        if (dn && !up) speed_m = (speed_m > 0) ? speed_m - 1 : 0;
        if (m) begin
            if (mode_m == 1) dir_up_m = 1'b1;
            mode_m = (mode_m + 1) % 4;
        end
        cyc_m++;
    endtask

    task automatic compare();
        check("tick",  TICK,  m_tick());
        check("step",  STEP,  step_m);
        check("speed", SPEED, speed_m);
        check("mode",  MODE,  mode_m);
        check("led",   LED,   led_m);
    endtask

    // Called at a falling edge: apply buttons for one rising edge, then check.
    task automatic cycle(input bit up, input bit dn, input bit m);
        BTN_UP = up; BTN_DN = dn; BTN_MODE = m;
        @(posedge CLK);
        model_clock(up, dn, m);
        @(negedge CLK);
        BTN_UP = 1'b0; BTN_DN = 1'b0; BTN_MODE = 1'b0;
        compare();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset pulse between clock edges, held across one rising edge.
    task automatic pulse_reset();
        #2 RST = 1'b0;
        #1 model_reset();
        compare();
        @(posedge CLK);
        @(negedge CLK);
        compare();
        RST = 1'b1;
    endtask

    initial begin
        model_reset();
        @(negedge CLK);
        compare();
        RST = 1'b1;

        idle(120);                                   // free-run forward at speed 0
        for (int i = 0; i < 5; i++) begin cycle(1'b1, 1'b0, 1'b0); idle(20); end
        for (int i = 0; i < 4; i++) begin cycle(1'b0, 1'b1, 1'b0); idle(20); end
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);                     // simultaneous press: no change
        idle(10);

        // mode press landing exactly on a tick, then walk through every mode
        while (!(m_tick() && mode_m == 0)) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        idle(40);
        cycle(1'b0, 1'b0, 1'b1);
        idle(80);

        // hold: many ticks at top speed with the step frozen
        while (mode_m != 3) cycle(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);
        idle(220);
        cycle(1'b0, 1'b1, 1'b0);
        idle(20);
        cycle(1'b0, 1'b0, 1'b1);

        // reset mid-run
        idle(17);
        pulse_reset();
        idle(40);

        for (int i = 0; i < 4000; i++) begin
            int r = $urandom_range(0, 999);
            if (r < 3) pulse_reset();
            else cycle($urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                       $urandom_range(0, 59) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
